// File: rtl/button_event_gen.sv
// button_event_gen: debounced level -> PRESS/RELEASE(/REPEAT) events
// 2-entry event FIFO; define BUTTON_EVENT_REPEAT_EN for auto-repeat
module button_event_gen #(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [1:0] event_code,
  output logic       overflow
);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;

  if (HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("HOLD_DELAY and REPEAT_PERIOD must be >= 1");
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int MAXT =
    (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_RPT
  } state_t;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
`else
  typedef enum logic {
    S_IDLE,
    S_HELD
  } state_t;
`endif

  state_t state_q;
  state_t state_d;

  logic       prev;
  logic       rise;
  logic       fall;
  logic       press_req;
  logic       rel_req;
  logic       rpt_req;

  logic [1:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       pop;
  logic       space;
  logic       rpt_ok;
  logic       push;
  logic       drop;
  logic [1:0] push_code;

  assign rise = in & ~prev;
  assign fall = ~in & prev;

  // Edge history and FSM state; reset adopts the current level
  always_ff @(posedge clk) begin
    prev <= in;
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  // Hold/repeat timer, cleared at each terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next state and event requests; a fall wins over a terminal count
  always_comb begin
    state_d   = state_q;
    press_req = 1'b0;
    rel_req   = 1'b0;
    rpt_req   = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          press_req = 1'b1;
          state_d   = S_HELD;
`ifdef BUTTON_EVENT_REPEAT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_HELD: begin
        if (fall) begin
          rel_req = 1'b1;
          state_d = S_IDLE;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (cnt_q == HOLD_LAST) begin
          rpt_req = 1'b1;
          cnt_d   = '0;
          state_d = S_RPT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
`ifdef BUTTON_EVENT_REPEAT_EN
      S_RPT: begin
        if (fall) begin
          rel_req = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == RPT_LAST) begin
          rpt_req = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign event_valid = (count != 2'd0);
  assign event_code  = event_valid ? mem[rd_ptr] : EV_PRESS;
  assign pop         = event_valid & event_ready;
  assign space       = (count != 2'd2) | pop;
  assign rpt_ok      = (count == 2'd0) |
                       ((count == 2'd1) & pop);

  // Push arbitration: REPEAT only into an empty FIFO, edges flag drops
  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    push_code = EV_PRESS;
    unique case (1'b1)
      press_req: begin
        push      = space;
        drop      = ~space;
        push_code = EV_PRESS;
      end
      rel_req: begin
        push      = space;
        drop      = ~space;
        push_code = EV_RELEASE;
      end
      rpt_req: begin
        push      = rpt_ok;
        push_code = EV_REPEAT;
      end
      default: ;
    endcase
  end

  // FIFO storage; slot contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_code;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: scoreboard bench for button_event_gen
// expected events queued at stimulus time, checked on handshake
module tb_button_event_gen;

  localparam int HD = 8;
  localparam int RP = 4;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;

  typedef struct {
    logic [1:0] code;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_code;
  logic       overflow;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errs   = 0;
  logic       hold_v = 1'b0;
  logic [1:0] hold_c = 2'b00;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  button_event_gen #(
    .HOLD_DELAY   (HD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_code (event_code),
    .overflow   (overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [1:0] c, input int at);
    exp_t e;
    e.code = c;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      step();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Pulse held for d cycles with ready high
  task automatic hold(input int d);
    int t;
    t  = cyc;
    in = 1'b1;
    expect_ev(EV_PRESS, t + 1);
`ifdef BUTTON_EVENT_REPEAT_EN
    for (int k = 0; HD + RP * k < d; k++) begin
      expect_ev(EV_REPEAT, t + 1 + HD + RP * k);
    end
`endif
    step(d);
    in = 1'b0;
    expect_ev(EV_RELEASE, t + d + 1);
    drain(d + 20);
    step(2);
  endtask

  // Handshake monitor and stall-stability check
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (hold_v) begin
        chk("stable", event_code, hold_c);
      end
      if (event_valid === 1'b1 && event_ready === 1'b1) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("code", event_code, e.code);
          if (e.at >= 0) begin
            chk("cycle", cyc, e.at);
          end
        end
      end
    end
    hold_v = (rst === 1'b0) && (event_valid === 1'b1) &&
             (event_ready !== 1'b1);
    hold_c = event_code;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    in          = 1'b1;
    event_ready = 1'b1;
    step(2);
    chk("rst_valid", event_valid, 0);
    chk("rst_code", event_code, 0);
    chk("rst_ovf", overflow, 0);

    rst = 1'b0;
    step(3);
    in = 1'b0;
    step(5);
    chk("no_evt_at_rst_level", event_valid, 0);

    hold(2);
    hold(1);
    hold(20);
    hold(12);
    hold(HD);
    hold(HD + 1);
    hold(40);

    event_ready = 1'b0;
    in = 1'b1;
    expect_ev(EV_PRESS, -1);
    step(2);
    in = 1'b0;
    expect_ev(EV_RELEASE, -1);
    step(2);
    chk("full_valid", event_valid, 1);
    chk("full_head", event_code, EV_PRESS);
    in = 1'b1;
    event_ready = 1'b1;
    expect_ev(EV_PRESS, -1);
    step(2);
    in = 1'b0;
    expect_ev(EV_RELEASE, -1);
    drain(20);
    chk("ovf_pushpop", overflow, 0);
    step(2);

    event_ready = 1'b0;
    in = 1'b1;
    expect_ev(EV_PRESS, -1);
    step(2);
    in = 1'b0;
    expect_ev(EV_RELEASE, -1);
    step(2);
    in = 1'b1;
    step(1);
    chk("ovf_set", overflow, 1);
    event_ready = 1'b1;
    step(1);
    in = 1'b0;
    expect_ev(EV_RELEASE, -1);
    drain(20);
    chk("ovf_sticky", overflow, 1);
    step(2);

    rst = 1'b1;
    step(1);
    chk("ovf_rst", overflow, 0);
    rst = 1'b0;
    step(2);
    event_ready = 1'b0;
    in = 1'b1;
    expect_ev(EV_PRESS, -1);
    step(20);
    chk("stall_valid", event_valid, 1);
    chk("stall_code", event_code, EV_PRESS);
    chk("rpt_no_ovf", overflow, 0);
    in = 1'b0;
    expect_ev(EV_RELEASE, -1);
    step(2);
    event_ready = 1'b1;
    drain(20);
    chk("rpt_drop_ovf", overflow, 0);
    step(2);

    event_ready = 1'b0;
    in = 1'b1;
    step(2);
    chk("pend_valid", event_valid, 1);
    rst = 1'b1;
    step(1);
    chk("midrst_valid", event_valid, 0);
    chk("midrst_code", event_code, 0);
    rst = 1'b0;
    event_ready = 1'b1;
    step(HD + 4);
    chk("post_rst_valid", event_valid, 0);
    in = 1'b0;
    step(4);
    chk("post_rst_rel", event_valid, 0);
    drain(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
